// File: rtl/sweep_sequencer.sv
// Segment-table program sequencer feeding base_freq/sweep_mode to the sweep controller.
// Define SEQ_PAUSE_EN to build the pause (dwell freeze) feature; otherwise pause_i is ignored.
module sweep_sequencer #(
  parameter int DEPTH         = 8,
  parameter int CYCLES_PER_MS = 100000,
  parameter int AW            = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [37:0]   wr_data_i,
  input  logic [AW:0]   num_entries_i,
  input  logic          loop_en_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          pause_i,
  output logic [19:0]   base_freq_o,
  output logic [1:0]    sweep_mode_o,
  output logic [AW-1:0] seg_idx_o,
  output logic          seg_start_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          wr_err_o
);

  // state   | meaning
  // S_IDLE  | waiting for start, table writable
  // S_LOAD  | table[idx] read; outputs and dwell timer load on the next edge
  // S_DWELL | segment active, ms prescaler and dwell down-counter running
  // S_DONE  | program finished; done pulses on the way back to idle
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

  localparam int            PW         = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MS - 1);
  localparam logic [PW-1:0] PRESC_END  = PW'(CYCLES_PER_MS - 2);
  localparam logic [PW-1:0] ONE_P      = PW'(1);
  localparam logic [AW-1:0] ONE_A      = AW'(1);
  localparam logic [AW:0]   ONE_N      = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_N    = (AW+1)'(DEPTH);
  localparam logic [19:0]   FREQ_MIN   = 20'd1000;
  localparam logic [19:0]   FREQ_MAX   = 20'd999000;
  localparam logic [19:0]   FREQ_RST   = 20'd100000;

  state_t        state_q;
  logic [37:0]   prog_q [DEPTH];
  logic [AW-1:0] idx_q;
  logic [AW:0]   n_q;
  logic          loop_q;
  logic [15:0]   dwell_q;
  logic [PW-1:0] presc_q;
  logic [19:0]   base_freq_q;
  logic [1:0]    sweep_mode_q;
  logic [AW-1:0] seg_idx_q;
  logic          seg_start_q;
  logic          busy_q;
  logic          done_q;
  logic          wr_err_q;
  logic          err_pend_q;

  logic [37:0]   entry;
  logic [19:0]   freq_d;
  logic [15:0]   dwell_d;
  logic          hold;
  logic          seg_end;
  logic          is_last;
  logic          start_ok;
  logic          err_req;
  logic          seg_load;

`ifdef SEQ_PAUSE_EN
  assign hold = pause_i;
`else
  logic pause_unused;
  assign pause_unused = pause_i;
  assign hold         = 1'b0;
`endif

  always_comb begin
    entry = prog_q[idx_q];
    freq_d = entry[37:18];
    if (entry[37:18] < FREQ_MIN) begin
      freq_d = FREQ_MIN;
    end else if (entry[37:18] > FREQ_MAX) begin
      freq_d = FREQ_MAX;
    end
    dwell_d  = (entry[15:0] == 16'd0) ? 16'd1 : entry[15:0];
    // End one cycle early so the LOAD cycle completes the dwell_ms*CYCLES_PER_MS period.
    seg_end  = (dwell_q == 16'd1) && (presc_q == PRESC_END) && !hold;
    is_last  = (({1'b0, idx_q}) + ONE_N) == n_q;
    start_ok = start_i && (num_entries_i != '0) && (num_entries_i <= DEPTH_N);
    err_req  = (wr_en_i && busy_q) || err_pend_q;
    seg_load = (state_q == S_LOAD) && !stop_i;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_q) begin
      prog_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      loop_q       <= 1'b0;
      dwell_q      <= '0;
      presc_q      <= '0;
      base_freq_q  <= FREQ_RST;
      sweep_mode_q <= 2'b00;
      seg_idx_q    <= '0;
      seg_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_err_q     <= 1'b0;
      err_pend_q   <= 1'b0;
    end else begin
      seg_start_q <= 1'b0;
      done_q      <= 1'b0;

      // A write error that would land on a seg_start is pushed back one cycle.
      if (seg_load) begin
        err_pend_q <= err_req;
        wr_err_q   <= 1'b0;
      end else begin
        err_pend_q <= 1'b0;
        wr_err_q   <= err_req;
      end

      if (stop_i) begin
        state_q      <= S_IDLE;
        busy_q       <= 1'b0;
        sweep_mode_q <= 2'b00;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_ok) begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
              n_q     <= num_entries_i;
              loop_q  <= loop_en_i;
              idx_q   <= '0;
            end
          end
          S_LOAD: begin
            state_q      <= S_DWELL;
            base_freq_q  <= freq_d;
            sweep_mode_q <= entry[17:16];
            seg_idx_q    <= idx_q;
            seg_start_q  <= 1'b1;
            dwell_q      <= dwell_d;
            presc_q      <= '0;
          end
          S_DWELL: begin
            if (seg_end) begin
              if (!is_last) begin
                idx_q   <= idx_q + ONE_A;
                state_q <= S_LOAD;
              end else if (loop_q) begin
                idx_q   <= '0;
                state_q <= S_LOAD;
              end else begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
              end
            end else if (!hold) begin
              if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                dwell_q <= dwell_q - 16'd1;
              end else begin
                presc_q <= presc_q + ONE_P;
              end
            end
          end
          S_DONE: begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign base_freq_o  = base_freq_q;
  assign sweep_mode_o = sweep_mode_q;
  assign seg_idx_o    = seg_idx_q;
  assign seg_start_o  = seg_start_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign wr_err_o     = wr_err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: directed scenarios plus random traffic against a
// timeline model (segment length in cycles, remaining-cycle countdown).
module tb_sweep_sequencer;
  localparam int DEPTH = 8;
  localparam int CPM   = 10;
`ifdef SEQ_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [2:0]  wr_addr_i = '0;
  logic [37:0] wr_data_i = '0;
  logic [3:0]  num_entries_i = '0;
  logic        loop_en_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        pause_i = 1'b0;
  logic [19:0] base_freq_o;
  logic [1:0]  sweep_mode_o;
  logic [2:0]  seg_idx_o;
  logic        seg_start_o;
  logic        busy_o;
  logic        done_o;
  logic        wr_err_o;

  always #5 clk = ~clk;

  sweep_sequencer #(.DEPTH(DEPTH), .CYCLES_PER_MS(CPM)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .num_entries_i(num_entries_i), .loop_en_i(loop_en_i),
    .start_i(start_i), .stop_i(stop_i), .pause_i(pause_i),
    .base_freq_o(base_freq_o), .sweep_mode_o(sweep_mode_o), .seg_idx_o(seg_idx_o),
    .seg_start_o(seg_start_o), .busy_o(busy_o), .done_o(done_o), .wr_err_o(wr_err_o)
  );

  int errors = 0;
  int checks = 0;

  // reference model
  logic [37:0] m_tab [DEPTH];
  bit          m_run = 1'b0;
  bit          m_loop = 1'b0;
  bit          m_pend = 1'b0;
  int          m_n = 0;
  int          m_next = 0;
  int          m_left = 0;
  logic [19:0] e_freq = 20'd100000;
  logic [1:0]  e_mode = 2'b00;
  logic [2:0]  e_idx = 3'd0;
  logic        e_ss = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;
  logic        e_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [19:0] clamp(input logic [19:0] f);
    if (f < 20'd1000) return 20'd1000;
    if (f > 20'd999000) return 20'd999000;
    return f;
  endfunction

  // Expected outputs for the next cycle, from the inputs driven this cycle.
  task automatic model_step();
    bit req;
    int dw;
    req = (wr_en_i && e_busy) || m_pend;
    if (wr_en_i && !e_busy) m_tab[wr_addr_i] = wr_data_i;
    e_ss   = 1'b0;
    e_done = 1'b0;
    if (rst_i) begin
      e_freq = 20'd100000; e_mode = 2'b00; e_idx = 3'd0; e_busy = 1'b0;
      e_err = 1'b0; m_run = 1'b0; m_pend = 1'b0;
    end else begin
      if (stop_i) begin
        e_busy = 1'b0; e_mode = 2'b00; m_run = 1'b0;
      end else if (m_run) begin
        if (m_left == 1) begin
          if (m_next == m_n) begin
            e_done = 1'b1;
            m_run  = 1'b0;
          end else begin
            e_freq = clamp(m_tab[m_next][37:18]);
            e_mode = m_tab[m_next][17:16];
            e_idx  = 3'(m_next);
            e_ss   = 1'b1;
            e_busy = 1'b1;
            dw     = int'(m_tab[m_next][15:0]);
            m_left = ((dw == 0) ? 1 : dw) * CPM;
            m_next++;
            if (m_next == m_n && m_loop) m_next = 0;
          end
        end else begin
          if (!(PAUSE_ON && pause_i)) m_left--;
          if (m_left == 1 && m_next == m_n) e_busy = 1'b0;
        end
      end else if (start_i && num_entries_i != 4'd0 && int'(num_entries_i) <= DEPTH) begin
        m_run = 1'b1; m_n = int'(num_entries_i); m_loop = loop_en_i;
        m_next = 0; m_left = 1; e_busy = 1'b1;
      end
      if (e_ss) begin
        m_pend = req; e_err = 1'b0;
      end else begin
        e_err = req; m_pend = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    chk("base_freq", 32'(base_freq_o), 32'(e_freq));
    chk("sweep_mode", 32'(sweep_mode_o), 32'(e_mode));
    chk("seg_idx", 32'(seg_idx_o), 32'(e_idx));
    chk("seg_start", 32'(seg_start_o), 32'(e_ss));
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("done", 32'(done_o), 32'(e_done));
    chk("wr_err", 32'(wr_err_o), 32'(e_err));
    rst_i = 1'b0; wr_en_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic wr(input int a, input logic [19:0] f, input logic [1:0] m, input logic [15:0] d);
    wr_en_i = 1'b1; wr_addr_i = 3'(a); wr_data_i = {f, m, d};
    tick();
  endtask

  task automatic go(input int n, input bit lp);
    num_entries_i = 4'(n); loop_en_i = lp; start_i = 1'b1;
    tick();
  endtask

  function automatic logic [37:0] rand_entry();
    logic [19:0] f;
    case ($urandom_range(0, 2))
      0:       f = 20'($urandom_range(0, 1999));
      1:       f = 20'($urandom_range(995000, 1048575));
      default: f = 20'($urandom_range(0, 1048575));
    endcase
    return {f, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
  endfunction

  initial begin
    rst_i = 1'b1; tick();
    rst_i = 1'b1; tick();
    idle(2);

    // two-segment one-shot program
    wr(0, 20'd50000, 2'b00, 16'd3);
    wr(1, 20'd200000, 2'b01, 16'd2);
    for (int a = 2; a < DEPTH; a++) begin
      wr_en_i = 1'b1; wr_addr_i = 3'(a); wr_data_i = rand_entry(); tick();
    end
    go(2, 1'b0); idle(60);

    // looping program aborted during the second pass of entry 1
    go(2, 1'b1); idle(86); stop_i = 1'b1; tick(); idle(5);

    // clamping and zero dwell
    wr(0, 20'd500, 2'b10, 16'd0);
    wr(1, 20'hFFFFF, 2'b00, 16'd1);
    go(2, 1'b0); idle(30);

    // ignored starts, write while busy, start and stop together
    go(0, 1'b0); idle(3);
    go(9, 1'b0); idle(3);
    go(3, 1'b1); idle(10);
    wr(1, 20'd12345, 2'b11, 16'd7); idle(5);
    stop_i = 1'b1; tick(); idle(2);
    go(3, 1'b0); idle(70);
    num_entries_i = 4'd2; start_i = 1'b1; stop_i = 1'b1; tick(); idle(3);

    // pause mid segment
    wr(0, 20'd70000, 2'b01, 16'd3);
    go(1, 1'b0); idle(8);
    repeat (7) begin pause_i = 1'b1; tick(); end
    idle(40);

    // reset during dwell
    go(2, 1'b0); idle(12); rst_i = 1'b1; tick(); idle(3);

    for (int ep = 0; ep < 40; ep++) begin
      repeat ($urandom_range(0, 3)) begin
        wr_en_i = 1'b1; wr_addr_i = 3'($urandom_range(0, 7)); wr_data_i = rand_entry(); tick();
      end
      go(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 120; c++) begin
        wr_en_i   = ($urandom_range(0, 5) == 0);
        wr_addr_i = 3'($urandom_range(0, 7));
        wr_data_i = rand_entry();
        stop_i    = ($urandom_range(0, 99) == 0);
        pause_i   = ($urandom_range(0, 3) == 0);
        start_i   = ($urandom_range(0, 29) == 0);
        rst_i     = ($urandom_range(0, 299) == 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
